// File: rtl/mmio_pkg.sv
// mmio_pkg: shared addresses, TX state encoding and tohost pass code for the console block
package mmio_pkg;
  localparam logic [31:0] CONSOLE_ADDR_DEFAULT = 32'h0000_0100;
  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_0104;
  localparam logic [31:0] TOHOST_PASS = 32'd1;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    START = 2'd1,
    DATA = 2'd2,
    STOP = 2'd3
  } tx_state_t;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: count-based byte FIFO that accepts a push while full if a pop happens on the same edge
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic [7:0] din,
  input  logic pop,
  output logic [7:0] dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/mmio_console_tx.sv
// mmio_console_tx: store-port console that queues bytes for UART 8N1 output and latches the tohost word
module mmio_console_tx
  import mmio_pkg::*;
#(
  parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEFAULT,
  parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEFAULT,
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic memwriteM,
  input  logic [31:0] dataAdrM,
  input  logic [31:0] writedataM,
  output logic tx,
  output logic busy,
  output logic fifo_full,
  output logic overflow,
  output logic done,
  output logic pass,
  output logic [31:0] done_code
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  tx_state_t state, state_n;
  logic [CW-1:0] baud, baud_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n, fifo_dout;
  logic [NW-1:0] count;
  logic console_wr, tohost_wr, pop, empty, bit_end, tx_n;
  assign console_wr = memwriteM && dataAdrM == CONSOLE_ADDR;
  assign tohost_wr = memwriteM && dataAdrM == TOHOST_ADDR && writedataM != '0 && !done;
  assign pop = state == IDLE && !empty;
  assign busy = state != IDLE || count != '0;
  assign bit_end = baud == CW'(CLKS_PER_BIT - 1);
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(console_wr),
    .din(writedataM[7:0]),
    .pop(pop),
    .dout(fifo_dout),
    .count(count),
    .full(fifo_full),
    .empty(empty)
  );
  always_comb begin
    state_n = state;
    baud_n = bit_end ? '0 : baud + 1'b1;
    idx_n = idx;
    shift_n = shift;
    if (state == IDLE) begin
      baud_n = '0;
      if (pop) begin
        state_n = START;
        shift_n = fifo_dout;
      end
    end else if (bit_end) begin
      case (state)
        START: state_n = DATA;
        DATA: state_n = idx == 3'd7 ? STOP : DATA;
        default: state_n = IDLE;
      endcase
      idx_n = state == DATA ? idx + 1'b1 : '0;
      if (state == DATA) shift_n = shift >> 1;
    end
    // tx is registered, so it follows the state and shift values being loaded this edge
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      baud <= '0;
      idx <= '0;
      shift <= '0;
      tx <= 1'b1;
      overflow <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      done_code <= '0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      idx <= idx_n;
      shift <= shift_n;
      tx <= tx_n;
      if (console_wr && fifo_full && !pop) overflow <= 1'b1;
      if (tohost_wr) begin
        done <= 1'b1;
        done_code <= writedataM;
        pass <= writedataM == TOHOST_PASS;
      end
    end
  end
endmodule

// File: tb/tb_mmio_console_tx.sv
// tb_mmio_console_tx: directed stores with a UART-decoding monitor checked against an expected-byte queue
module tb_mmio_console_tx;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic memwriteM = 1'b0;
  logic [31:0] dataAdrM = '0;
  logic [31:0] writedataM = '0;
  logic tx, busy, fifo_full, overflow, done, pass;
  logic [31:0] done_code;
  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  mmio_console_tx dut (
    .clock(clock),
    .reset(reset),
    .memwriteM(memwriteM),
    .dataAdrM(dataAdrM),
    .writedataM(writedataM),
    .tx(tx),
    .busy(busy),
    .fifo_full(fifo_full),
    .overflow(overflow),
    .done(done),
    .pass(pass),
    .done_code(done_code)
  );
  always #5 clock = ~clock;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask
  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    memwriteM = 1'b1;
    dataAdrM = addr;
    writedataM = data;
    @(posedge clock);
    #1;
    memwriteM = 1'b0;
  endtask
  task automatic console(input logic [7:0] b, input logic expect_out);
    if (expect_out) exp_q.push_back(b);
    store(32'h100, {24'hFFFF_FF, b});
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 2000) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("drain_timeout", 32'(n >= 2000), 32'd0);
  endtask
  initial begin : monitor
    logic rx_busy = 1'b0;
    int t = 0;
    logic [7:0] rx = '0;
    forever begin
      @(negedge clock);
      if (reset) rx_busy = 1'b0;
      else if (!rx_busy) begin
        if (!tx) begin
          rx_busy = 1'b1;
          t = 0;
        end
      end else begin
        t++;
        if (t == 2) check("start_bit", 32'(tx), 32'd0);
        if (t >= 6 && t <= 34 && t % 4 == 2) rx[(t - 6) / 4] = tx;
        if (t == 38) begin
          check("stop_bit", 32'(tx), 32'd1);
          if (exp_q.size() == 0) check("unexpected_frame", 32'(rx), 32'hFFFF_FFFF);
          else check("frame_byte", 32'(rx), 32'(exp_q.pop_front()));
          rx_busy = 1'b0;
        end
      end
    end
  end
  initial begin
    int bad;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clock);
      #1;
      if ({tx, busy, done, overflow} !== 4'b1000) bad++;
    end
    check("idle_after_reset", 32'(bad), 32'd0);
    console(8'h41, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clock);
      #1;
      check("start_low", 32'(tx), 32'd0);
    end
    repeat (36) @(posedge clock);
    #1;
    check("busy_at_n40", 32'(busy), 32'd1);
    @(posedge clock);
    #1;
    check("busy_after_n41", 32'(busy), 32'd0);
    wait_idle();
    console(8'h48, 1'b1);
    console(8'h69, 1'b1);
    repeat (40) @(posedge clock);
    #1;
    check("gap_idle_tx", 32'(tx), 32'd1);
    check("gap_busy", 32'(busy), 32'd1);
    @(posedge clock);
    #1;
    check("second_start", 32'(tx), 32'd0);
    check("no_overflow", 32'(overflow), 32'd0);
    wait_idle();
    for (int i = 0; i < 9; i++) console(8'h30 + 8'(i), 1'b1);
    check("full_before_drop", 32'(fifo_full), 32'd1);
    check("overflow_before_drop", 32'(overflow), 32'd0);
    console(8'h39, 1'b0);
    check("full_at_drop", 32'(fifo_full), 32'd1);
    check("overflow_set", 32'(overflow), 32'd1);
    wait_idle();
    check("overflow_sticky", 32'(overflow), 32'd1);
    store(32'h104, 32'd0);
    check("done_zero_store", 32'(done), 32'd0);
    store(32'h200, 32'd1);
    check("done_other_addr", 32'(done), 32'd0);
    store(32'h104, 32'd1);
    check("done_set", 32'(done), 32'd1);
    check("pass_set", 32'(pass), 32'd1);
    check("done_code", done_code, 32'd1);
    store(32'h104, 32'd3);
    check("code_held", done_code, 32'd1);
    check("pass_held", 32'(pass), 32'd1);
    console(8'h55, 1'b0);
    console(8'h11, 1'b0);
    console(8'h22, 1'b0);
    repeat (6) @(posedge clock);
    #1;
    check("mid_frame_tx", 32'(tx), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_full", 32'(fifo_full), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      #1;
      if ({tx, busy} !== 2'b10) bad++;
    end
    check("quiet_after_abort", 32'(bad), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
